// File: rtl/act_feeder_pkg.sv
// Shared types and constants for the activation skew feeder.
package act_feeder_pkg;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} feeder_state_t;
  localparam logic [31:0] FP_ZERO = 32'h0;
endpackage

// File: rtl/skew_delay_line.sv
// DELAY-stage shift register with enable and synchronous clear; one per array row.
module skew_delay_line #(
  parameter int DATA_W = 32,
  parameter int DELAY  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic [DELAY-1:0][DATA_W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clr) begin
      sr_d = '0;
    end else if (en) begin
      sr_d[0] = din;
      for (int s = 1; s < DELAY; s++) sr_d[s] = sr_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign dout = sr_q[DELAY-1];
endmodule

// File: rtl/act_skew_feeder.sv
// West-edge feeder: diagonally skews activation beats into the systolic array,
// flushes with zeros after the last beat, then pulses done. Option: ACT_FEEDER_STALL_CNT_EN.
module act_skew_feeder
  import act_feeder_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] in_data,
  input  logic                   in_last,
  output logic [ROWS*DATA_W-1:0] west_out,
  output logic                   compute,
  output logic                   busy,
  output logic                   done
`ifdef ACT_FEEDER_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]       stall_cnt
`endif
);
  localparam int DC_W       = (ROWS > 2) ? $clog2(ROWS) : 1;
  localparam int DRAIN_INIT = (ROWS > 1) ? ROWS - 2 : 0;

  feeder_state_t   state_q, state_d;
  logic [DC_W-1:0] dcnt_q, dcnt_d;
  logic            compute_q, compute_d;
  logic            done_q, done_d;
  logic            advance, clr_skew;

  assign in_ready = (state_q == FEED);
  assign advance  = (in_ready & in_valid) | (state_q == DRAIN);
  assign clr_skew = (state_q == IDLE) & start;

  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    done_d    = 1'b0;
    compute_d = advance;
    case (state_q)
      IDLE:  if (start) state_d = FEED;
      FEED: begin
        if (in_valid && in_last) begin
          if (ROWS == 1) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
            dcnt_d  = DC_W'(DRAIN_INIT);
          end
        end
      end
      DRAIN: begin
        if (dcnt_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          dcnt_d = dcnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef ACT_FEEDER_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  always_comb begin
    stall_d = stall_q;
    if (clr_skew)
      stall_d = '0;
    else if ((state_q == FEED) && !in_valid && (stall_q != '1))
      stall_d = stall_q + 1'b1;
  end
  assign stall_cnt = stall_q;
`endif

  // compute is the registered advance, so the strobe seen in the DONE cycle
  // belongs to the final drain shift that presents row ROWS-1's last element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dcnt_q    <= '0;
      compute_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef ACT_FEEDER_STALL_CNT_EN
      stall_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      compute_q <= compute_d;
      done_q    <= done_d;
`ifdef ACT_FEEDER_STALL_CNT_EN
      stall_q   <= stall_d;
`endif
    end
  end

  assign compute = compute_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_W-1:0] din;
    assign din = (state_q == DRAIN) ? DATA_W'(FP_ZERO) : in_data[r*DATA_W +: DATA_W];
    skew_delay_line #(.DATA_W(DATA_W), .DELAY(r + 1)) u_dl (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (advance),
      .clr  (clr_skew),
      .din  (din),
      .dout (west_out[r*DATA_W +: DATA_W])
    );
  end
endmodule
